score_keeper: RTL

- Downstream consumer of the game control FSM's judgment outputs: `changeScore` (event strobe), `addScore` (hit/miss) and `songDone`.
- Maintains the running score as packed BCD (4 digits, saturating at 9999), the hit streak, the streak multiplier and a session high score.
- Outputs feed the HEX display decoders and the VGA score overlay.

---
 rtl/score_keeper.sv | 132 +++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Score keeper: packed-BCD running score with streak multiplier and session high score,
// driven by the judgment strobes of the game control FSM.
module score_keeper #(
  parameter int unsigned T1          = 4,
  parameter int unsigned T2          = 8,
  parameter int unsigned T3          = 16,
  parameter int unsigned BASE_POINTS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        changeScore,
  input  logic        addScore,
  input  logic        songDone,
  output logic [15:0] score,
  output logic [15:0] highScore,
  output logic [7:0]  streak,
  output logic [2:0]  multiplier,
  output logic        newHigh,
  output logic        gameOver
);

  typedef enum logic [1:0] {StIdle, StPlaying, StFinish, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [15:0] high_q, high_d;
  logic [7:0]  streak_q, streak_d;
  logic [2:0]  mult_q, mult_d;
  logic        new_high_q, new_high_d;
  logic [3:0]  points;

  // Adds a single-digit increment to a 4-digit packed BCD value, saturating at 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [3:0] inc);
    logic [15:0] sum;
    logic [4:0]  dig;
    logic        carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      dig = {1'b0, a[4*i +: 4]} + {4'd0, carry} + ((i == 0) ? {1'b0, inc} : 5'd0);
      if (dig > 5'd9) begin
        dig   = dig - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = dig[3:0];
    end
    if (carry) sum = 16'h9999;
    return sum;
  endfunction

  function automatic logic [2:0] mult_for(input logic [7:0] s);
    logic [2:0] m;
    if (32'(s) >= T3)      m = 3'd4;
    else if (32'(s) >= T2) m = 3'd3;
    else if (32'(s) >= T1) m = 3'd2;
    else                   m = 3'd1;
    return m;
  endfunction

  assign points = 4'(BASE_POINTS) * {1'b0, mult_q};

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    streak_d   = streak_q;
    mult_d     = mult_q;
    new_high_d = new_high_q;
    if (start) begin
      state_d    = StPlaying;
      score_d    = '0;
      streak_d   = '0;
      mult_d     = 3'd1;
      new_high_d = 1'b0;
    end else begin
      case (state_q)
        StPlaying: begin
          if (changeScore) begin
            if (addScore) begin
              score_d  = bcd_add(score_q, points);
              streak_d = (streak_q == 8'd255) ? 8'd255 : streak_q + 8'd1;
              mult_d   = mult_for(streak_d);
            end else begin
              streak_d = '0;
              mult_d   = 3'd1;
            end
          end
          if (songDone) state_d = StFinish;
        end
        StFinish: begin
          // Packed BCD orders the same as unsigned binary.
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end
          state_d = StDone;
        end
        StIdle, StDone: state_d = state_q;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      score_q    <= '0;
      high_q     <= '0;
      streak_q   <= '0;
      mult_q     <= 3'd1;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      streak_q   <= streak_d;
      mult_q     <= mult_d;
      new_high_q <= new_high_d;
    end
  end

  assign score      = score_q;
  assign highScore  = high_q;
  assign streak     = streak_q;
  assign multiplier = mult_q;
  assign newHigh    = new_high_q;
  assign gameOver   = (state_q == StDone);

endmodule
